jt03_wrq: RTL and testbench

- CPU-side write queue placed directly upstream of the YM2203 wrapper.
- Accepts back-to-back host register writes (address-port and data-port) into a FIFO.
- Replays each write to the chip bus as a one-cen-period cs_n/wr_n strobe, followed by the chip-mandated wait.
- The host never needs to poll the chip busy flag.

---
 rtl/jt03_wrq_pkg.sv | 25 ++
 rtl/jt03_wrq_if.sv | 27 ++
 rtl/jt03_wrq_fifo.sv | 82 ++++++++
 rtl/jt03_wrq.sv | 122 ++++++++++++
 tb/tb_jt03_wrq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jt03_wrq_pkg.sv
// Shared types and constants for the YM2203 write queue.
package jt03_wrq_pkg;

  // Chip-side replay FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // One queued write: {a0, data}.
  localparam int ENTRY_W = 9;

  // Wait counter width; must hold the longest FM data-port wait (83).
  localparam int WCNT_W = 7;

  // Registers below this address belong to the SSG block and need no wait.
  localparam logic [7:0] SSG_BOUND = 8'h10;

  // True when a data-port write to this register hits the FM block.
  function automatic logic is_fm_reg(input logic [7:0] reg_addr);
    return reg_addr >= SSG_BOUND;
  endfunction

endpackage

// File: rtl/jt03_wrq_if.sv
// Host-side and chip-side signal bundle of the write queue.
interface jt03_wrq_if;
  logic       host_wr;
  logic       host_a0;
  logic [7:0] host_din;
  logic       ovf_clr;
  logic       full;
  logic       empty;
  logic       idle;
  logic       ovf;
  logic       chip_cs_n;
  logic       chip_wr_n;
  logic       chip_addr;
  logic [7:0] chip_din;

  // Host / test side.
  modport master (
    output host_wr, host_a0, host_din, ovf_clr,
    input  full, empty, idle, ovf, chip_cs_n, chip_wr_n, chip_addr, chip_din
  );

  // Write queue side.
  modport slave (
    input  host_wr, host_a0, host_din, ovf_clr,
    output full, empty, idle, ovf, chip_cs_n, chip_wr_n, chip_addr, chip_din
  );
endinterface

// File: rtl/jt03_wrq_fifo.sv
// 2^AW-entry FIFO with occupancy count and sticky overflow flag.
// Writes land on clk; the head entry is readable combinationally.
module jt03_wrq_fifo
  import jt03_wrq_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  input  logic               ovf_clr,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic               ovf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;
  assign dout  = mem_q[rd_ptr_q];

  // Accept/commit decisions, pointer and count updates, overflow tracking.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    pop_ok  = pop && !empty;
    // A full queue still accepts a write when the head leaves in the same clk.
    push_ok = push && (!full || pop_ok);

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (ovf_clr)                        ovf_d = 1'b0;
    else if (push && full && !pop_ok)   ovf_d = 1'b1;
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the count alone decides which entries are valid.
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jt03_wrq.sv
// Write queue in front of the YM2203: buffers host writes and replays
// them as one-cen cs_n/wr_n strobes followed by the chip busy time.
module jt03_wrq
  import jt03_wrq_pkg::*;
#(
  parameter int AW            = 4,
  parameter int ADDR_WAIT     = 17,
  parameter int DATA_WAIT_FM  = 83,
  parameter int DATA_WAIT_SSG = 0
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  jt03_wrq_if.slave  bus
);

  localparam logic [WCNT_W-1:0] ADDR_WAIT_C = WCNT_W'(ADDR_WAIT);
  localparam logic [WCNT_W-1:0] FM_WAIT_C   = WCNT_W'(DATA_WAIT_FM);
  localparam logic [WCNT_W-1:0] SSG_WAIT_C  = WCNT_W'(DATA_WAIT_SSG);

  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_full, fifo_empty, fifo_ovf;
  logic               pop;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [WCNT_W-1:0]  wait_val;
  logic [7:0]         reg_q, reg_d;
  logic               cs_n_q, cs_n_d;
  logic               wr_n_q, wr_n_d;
  logic               addr_q, addr_d;
  logic [7:0]         din_q, din_d;

  jt03_wrq_fifo #(.AW(AW)) u_fifo (
    .rst     (rst),
    .clk     (clk),
    .push    (bus.host_wr),
    .din     ({bus.host_a0, bus.host_din}),
    .pop     (pop),
    .ovf_clr (bus.ovf_clr),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ovf     (fifo_ovf)
  );

  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.ovf       = fifo_ovf;
  assign bus.idle      = fifo_empty && (state_q == IDLE);
  assign bus.chip_cs_n = cs_n_q;
  assign bus.chip_wr_n = wr_n_q;
  assign bus.chip_addr = addr_q;
  assign bus.chip_din  = din_q;

  // Replay FSM: pop and strobe, release and load the busy time, count it down.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    reg_d    = reg_q;
    cs_n_d   = cs_n_q;
    wr_n_d   = wr_n_q;
    addr_d   = addr_q;
    din_d    = din_q;
    pop      = 1'b0;
    wait_val = '0;

    if (cen) begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop             = 1'b1;
            {addr_d, din_d} = fifo_dout;
            cs_n_d          = 1'b0;
            wr_n_d          = 1'b0;
            state_d         = STROBE;
          end
        end
        STROBE: begin
          cs_n_d = 1'b1;
          wr_n_d = 1'b1;
          if (!addr_q) begin
            // Address-port write: remember which register later data goes to.
            wait_val = ADDR_WAIT_C;
            reg_d    = din_q;
          end else begin
            wait_val = is_fm_reg(reg_q) ? FM_WAIT_C : SSG_WAIT_C;
          end
          wcnt_d  = wait_val;
          state_d = (wait_val != '0) ? WAIT : IDLE;
        end
        WAIT: begin
          wcnt_d = wcnt_q - WCNT_W'(1);
          if (wcnt_q == WCNT_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, counter, register latch and chip-bus output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      reg_q   <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      reg_q   <= reg_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: tb/tb_jt03_wrq.sv
// Directed bench for the YM2203 write queue.
module tb_jt03_wrq;

  logic clk = 1'b0;
  logic rst;
  logic cen_lvl;
  logic cen_mode;
  logic cen_div = 1'b0;
  logic cen;

  jt03_wrq_if bus ();

  assign cen = cen_mode ? cen_div : cen_lvl;

  jt03_wrq dut (
    .rst (rst),
    .clk (clk),
    .cen (cen),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  // Free-running clk counter used to time strobe starts.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 1-in-6 clock enable.
  int unsigned div_cnt = 0;
  always @(negedge clk) begin
    cen_div <= (div_cnt == 0);
    div_cnt <= (div_cnt == 5) ? 0 : div_cnt + 1;
  end

  // Strobe monitor: start time and content of each cs_n pulse, and its width in clk.
  int unsigned st_cyc[$];
  logic [8:0]  st_ent[$];
  int unsigned widths[$];
  int unsigned low_run = 0;
  logic        cs_prev = 1'b1;
  always @(negedge clk) begin
    if (!bus.chip_cs_n) begin
      if (cs_prev) begin
        st_cyc.push_back(cyc);
        st_ent.push_back({bus.chip_addr, bus.chip_din});
      end
      low_run = low_run + 1;
    end else if (low_run != 0) begin
      widths.push_back(low_run);
      low_run = 0;
    end
    cs_prev = bus.chip_cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic a0, input logic [7:0] d);
    bus.host_wr  = 1'b1;
    bus.host_a0  = a0;
    bus.host_din = d;
    step();
    bus.host_wr  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!bus.idle && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(bus.idle), 32'd1);
  endtask

  // Entry pushed at position i of the fill test.
  function automatic logic [8:0] fill_entry(input int i);
    logic [7:0] d;
    d = (i % 2 == 0) ? 8'(i) : 8'(8'hA0 + i);
    return {1'(i % 2), d};
  endfunction

  initial begin
    int unsigned c0;
    int unsigned b;
    int unsigned bw;
    logic [8:0]  ent;
    int unsigned exp_t1 [5] = '{2, 21, 106, 125, 127};
    logic [8:0]  exp_e1 [5] = '{9'h028, 9'h1F0, 9'h007, 9'h138, 9'h02B};

    rst          = 1'b1;
    cen_lvl      = 1'b1;
    cen_mode     = 1'b0;
    bus.host_wr  = 1'b0;
    bus.host_a0  = 1'b0;
    bus.host_din = 8'h00;
    bus.ovf_clr  = 1'b0;
    repeat (3) step();

    // Reset state.
    check("rst_full",  32'(bus.full),      32'd0);
    check("rst_empty", 32'(bus.empty),     32'd1);
    check("rst_idle",  32'(bus.idle),      32'd1);
    check("rst_ovf",   32'(bus.ovf),       32'd0);
    check("rst_cs_n",  32'(bus.chip_cs_n), 32'd1);
    check("rst_wr_n",  32'(bus.chip_wr_n), 32'd1);
    check("rst_addr",  32'(bus.chip_addr), 32'd0);
    check("rst_din",   32'(bus.chip_din),  32'd0);
    rst = 1'b0;
    step();
    check("post_rst_idle", 32'(bus.idle), 32'd1);

    // Address/data pair into FM register, then SSG register pair, then one more.
    b  = st_cyc.size();
    c0 = cyc;
    push(1'b0, 8'h28);
    check("t1_not_empty", 32'(bus.empty), 32'd0);
    check("t1_cs_n_before", 32'(bus.chip_cs_n), 32'd1);
    push(1'b1, 8'hF0);
    check("t1_cs_n_low",  32'(bus.chip_cs_n), 32'd0);
    check("t1_wr_n_low",  32'(bus.chip_wr_n), 32'd0);
    check("t1_addr",      32'(bus.chip_addr), 32'd0);
    check("t1_din",       32'(bus.chip_din),  32'h28);
    push(1'b0, 8'h07);
    check("t1_cs_n_rel",  32'(bus.chip_cs_n), 32'd1);
    check("t1_wr_n_rel",  32'(bus.chip_wr_n), 32'd1);
    check("t1_hold_din",  32'(bus.chip_din),  32'h28);
    push(1'b1, 8'h38);
    push(1'b0, 8'h2B);
    wait_idle("t1_idle_timeout", 400);
    check("t1_n_strobes", st_cyc.size() - b, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t1_start%0d", i), st_cyc[b + i] - c0, exp_t1[i]);
      check($sformatf("t1_entry%0d", i), 32'(st_ent[b + i]), 32'(exp_e1[i]));
    end
    check("t1_width", widths[widths.size() - 1], 32'd1);

    // Fill with the FSM stalled, overflow, clear, and clear-vs-set priority.
    cen_lvl = 1'b0;
    b = st_cyc.size();
    for (int i = 0; i < 15; i++) begin
      ent = fill_entry(i);
      push(ent[8], ent[7:0]);
    end
    check("fill15_full", 32'(bus.full), 32'd0);
    ent = fill_entry(15);
    push(ent[8], ent[7:0]);
    check("fill16_full",  32'(bus.full),  32'd1);
    check("fill16_empty", 32'(bus.empty), 32'd0);
    check("fill16_ovf",   32'(bus.ovf),   32'd0);
    push(1'b1, 8'hFF);
    check("drop_ovf",  32'(bus.ovf),  32'd1);
    check("drop_full", 32'(bus.full), 32'd1);
    step();
    check("ovf_sticky", 32'(bus.ovf), 32'd1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.ovf), 32'd0);
    bus.ovf_clr = 1'b1;
    push(1'b1, 8'hEE);
    bus.ovf_clr = 1'b0;
    check("ovf_clr_priority", 32'(bus.ovf), 32'd0);
    check("no_strobe_stalled", st_cyc.size() - b, 32'd0);

    // Push and pop in the same clk while full.
    cen_lvl = 1'b1;
    push(1'b0, 8'h5A);
    cen_lvl = 1'b0;
    check("pp_full",  32'(bus.full),      32'd1);
    check("pp_ovf",   32'(bus.ovf),       32'd0);
    check("pp_cs_n",  32'(bus.chip_cs_n), 32'd0);
    step();
    step();
    check("pp_cs_n_stall", 32'(bus.chip_cs_n), 32'd0);
    check("pp_full_stall", 32'(bus.full),      32'd1);
    cen_lvl = 1'b1;
    wait_idle("drain_idle_timeout", 3000);
    check("drain_n_strobes", st_cyc.size() - b, 32'd17);
    for (int i = 0; i < 16; i++)
      check($sformatf("drain_entry%0d", i), 32'(st_ent[b + i]), 32'(fill_entry(i)));
    check("drain_entry16", 32'(st_ent[b + 16]), 32'h05A);
    check("drain_ovf", 32'(bus.ovf), 32'd0);

    // Clock enable 1-in-6: widths and waits scale by 6.
    cen_mode = 1'b1;
    b  = st_cyc.size();
    bw = widths.size();
    push(1'b0, 8'h03);
    push(1'b1, 8'h44);
    push(1'b0, 8'h05);
    wait_idle("cen6_idle_timeout", 1500);
    check("cen6_n_strobes", st_cyc.size() - b, 32'd3);
    check("cen6_gap_addr", st_cyc[b + 1] - st_cyc[b],     32'd114);
    check("cen6_gap_ssg",  st_cyc[b + 2] - st_cyc[b + 1], 32'd12);
    for (int i = 0; i < 3; i++)
      check($sformatf("cen6_width%0d", i), widths[bw + i], 32'd6);
    check("cen6_entry1", 32'(st_ent[b + 1]), 32'h144);
    cen_mode = 1'b0;
    cen_lvl  = 1'b1;
    step();

    // Reset while waiting with five entries queued.
    push(1'b0, 8'h30);
    push(1'b1, 8'h31);
    push(1'b0, 8'h32);
    push(1'b1, 8'h33);
    push(1'b0, 8'h34);
    push(1'b1, 8'h35);
    check("mid_empty", 32'(bus.empty), 32'd0);
    check("mid_idle",  32'(bus.idle),  32'd0);
    check("mid_din",   32'(bus.chip_din), 32'h30);
    rst = 1'b1;
    #1;
    check("arst_cs_n",  32'(bus.chip_cs_n), 32'd1);
    check("arst_empty", 32'(bus.empty),     32'd1);
    check("arst_idle",  32'(bus.idle),      32'd1);
    check("arst_din",   32'(bus.chip_din),  32'd0);
    step();
    rst = 1'b0;
    b = st_cyc.size();
    step();
    check("rel_empty", 32'(bus.empty), 32'd1);
    check("rel_idle",  32'(bus.idle),  32'd1);
    check("rel_full",  32'(bus.full),  32'd0);
    repeat (60) step();
    check("rel_no_strobes", st_cyc.size() - b, 32'd0);
    check("rel_cs_n", 32'(bus.chip_cs_n), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
